gen_interrupciones: RTL and testbench

- Generates the processor's asynchronous-event requests: the one-cycle `interrupcion` and `clock_out` pulses that the control unit answers by pushing the return address and vectoring.
- Contains a programmable periodic timer, configured by the `clk_conf` instruction, and four edge-triggered external request lines.
- Applies fixed priority and tracks the in-service handler through the control unit's push/pop strobes.
- Re-arms only when that handler's own return pops.

---
 rtl/gen_interrupciones.sv | 166 ++++++++++++++++
 tb/tb_gen_interrupciones.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_interrupciones.sv
// gen_interrupciones: interrupt request generator for the processor core.
// A programmable periodic timer and N_EXT rising-edge external lines feed a
// pending register. A three-state FSM dispatches the highest-priority pending
// source as a one-cycle pulse, then tracks the handler through the control
// unit's push/pop strobes. It re-arms only when the handler's own return pops.
module gen_interrupciones #(
  parameter int N_EXT   = 4,
  parameter int DEPTH_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       conf_data,
  input  logic [N_EXT-1:0] irq_ext,
  input  logic             push,
  input  logic             pop,
  input  logic             s_interrupcion,
  output logic             interrupcion,
  output logic             clock_out,
  output logic [2:0]       irq_id,
  output logic             in_service
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FIRE    = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  // Timer configuration and counters
  logic [1:0]         r_base;
  logic [5:0]         r_umbral;
  logic [11:0]        r_presc;
  logic [5:0]         r_ticks;

  // Request tracking
  logic [N_EXT-1:0]   r_irq_q;
  logic [N_EXT:0]     r_pend;

  // Dispatch FSM
  logic [1:0]         r_state;
  logic [2:0]         r_irq_id;
  logic [DEPTH_W-1:0] r_depth;

  logic               w_presc_tick;
  logic               w_tick_en;
  logic [5:0]         w_ticks_inc;
  logic               w_timer_match;
  logic [N_EXT-1:0]   w_ext_rise;
  logic               w_dispatch;
  logic [2:0]         w_win_id;
  logic [N_EXT:0]     w_win_oh;
  logic [N_EXT:0]     w_clr;
  logic [N_EXT:0]     w_pend_next;

  // Prescaler tick: fires on the edge where the selected low bits wrap to 0
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    w_presc_tick = 1'b0;
    case (r_base)
      2'b00:   w_presc_tick = 1'b1;
      2'b01:   w_presc_tick = &r_presc[3:0];
      2'b10:   w_presc_tick = &r_presc[7:0];
      default: w_presc_tick = &r_presc[11:0];
    endcase
  end

  // A tick is discarded while config is loading, and umbral=0 disables the timer
  assign w_tick_en     = w_presc_tick && !enable && (r_umbral != 6'd0);
  assign w_ticks_inc   = r_ticks + 6'd1;
  assign w_timer_match = w_tick_en && (w_ticks_inc == r_umbral);

  // Timer: config load, free-running prescaler and tick counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_base   <= 2'b00;
      r_umbral <= 6'd0;
      r_presc  <= 12'd0;
      r_ticks  <= 6'd0;
    end else if (enable) begin
      r_base   <= conf_data[7:6];
      r_umbral <= conf_data[5:0];
      r_presc  <= 12'd0;
      r_ticks  <= 6'd0;
    end else begin
      r_presc <= r_presc + 12'd1;
      if (r_umbral == 6'd0)
        r_ticks <= 6'd0;
      else if (w_tick_en)
        r_ticks <= w_timer_match ? 6'd0 : w_ticks_inc;
    end
  end

  assign w_ext_rise = irq_ext & ~r_irq_q;
  assign w_dispatch = (r_state == S_IDLE) && (r_pend != '0);

  // Fixed priority: lowest pend index wins (timer first)
  always_comb begin
    w_win_id = 3'd0;
    w_win_oh = '0;
    for (int i = N_EXT; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_win_id    = 3'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  // Next pending set: clear the dispatched bit, then OR in new events so a
  // same-cycle re-request of that bit survives as a fresh pending
  always_comb begin
    w_clr       = w_dispatch ? w_win_oh : '0;
    w_pend_next = (r_pend & ~w_clr) | {w_ext_rise, w_timer_match};
    if (enable)
      w_pend_next[0] = 1'b0;
  end

  // Edge-detect register and pending bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_q <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_q <= irq_ext;
      r_pend  <= w_pend_next;
    end
  end

  // Dispatch FSM with nested-call depth tracking during service
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_irq_id <= 3'd0;
      r_depth  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_state  <= S_FIRE;
            r_irq_id <= w_win_id;
            r_depth  <= '0;
          end
        end
        S_FIRE: r_state <= S_SERVICE;
        S_SERVICE: begin
          if (pop) begin
            if (r_depth == '0)
              r_state <= S_IDLE;
            else
              r_depth <= r_depth - 1'b1;
          end else if (push && !s_interrupcion && (r_depth != '1)) begin
            r_depth <= r_depth + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registered state only
  assign clock_out    = (r_state == S_FIRE) && (r_irq_id == 3'd0);
  assign interrupcion = (r_state == S_FIRE) && (r_irq_id != 3'd0);
  assign irq_id       = r_irq_id;
  assign in_service   = (r_state != S_IDLE);

endmodule

// File: tb/tb_gen_interrupciones.sv
// Directed testbench for gen_interrupciones. Inputs change 1 ns after each
// rising edge; outputs are observed at the same point, reflecting that edge.
module tb_gen_interrupciones;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] conf_data;
  logic [3:0] irq_ext;
  logic       push;
  logic       pop;
  logic       s_interrupcion;
  logic       interrupcion;
  logic       clock_out;
  logic [2:0] irq_id;
  logic       in_service;

  int total;
  int bad;

  gen_interrupciones #(.N_EXT(4), .DEPTH_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .conf_data      (conf_data),
    .irq_ext        (irq_ext),
    .push           (push),
    .pop            (pop),
    .s_interrupcion (s_interrupcion),
    .interrupcion   (interrupcion),
    .clock_out      (clock_out),
    .irq_id         (irq_id),
    .in_service     (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; conf_data = 8'd0; irq_ext = 4'd0;
    push = 1'b0; pop = 1'b0; s_interrupcion = 1'b0;
    step(); step(); step();
    total++; if (interrupcion !== 1'b0) begin bad++; $display("FAIL rst_interrupcion got=%b exp=0", interrupcion); end
    total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL rst_clock_out got=%b exp=0", clock_out); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL rst_irq_id got=%0d exp=0", irq_id); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL rst_in_service got=%b exp=0", in_service); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ext_irq();
    int pulses;
    irq_ext = 4'b0001;
    step();  // edge sets pend[1]
    total++; if (interrupcion !== 1'b0) begin bad++; $display("FAIL ext_early got=%b exp=0", interrupcion); end
    step();  // FIRE
    total++; if (interrupcion !== 1'b1) begin bad++; $display("FAIL ext_pulse got=%b exp=1", interrupcion); end
    total++; if (irq_id !== 3'd1) begin bad++; $display("FAIL ext_irq_id got=%0d exp=1", irq_id); end
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL ext_in_service got=%b exp=1", in_service); end
    step();  // SERVICE
    total++; if (interrupcion !== 1'b0) begin bad++; $display("FAIL ext_pulse_width got=%b exp=0", interrupcion); end
    step(); step();
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL ext_still_service got=%b exp=1", in_service); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL ext_end_service got=%b exp=0", in_service); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (interrupcion) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL ext_level_no_repeat got=%0d exp=0", pulses); end
    irq_ext = 4'b0000;
    step();
  endtask

  task automatic test_timer();
    int pulses;
    int idle_cnt;
    enable = 1'b1; conf_data = 8'b00_000011;
    step();  // E0
    enable = 1'b0; conf_data = 8'd0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (clock_out) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL tmr_early got=%0d exp=0", pulses); end
    step();  // E0+4
    total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL tmr_first_pulse got=%b exp=1", clock_out); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL tmr_irq_id got=%0d exp=0", irq_id); end
    total++; if (interrupcion !== 1'b0) begin bad++; $display("FAIL tmr_no_ext got=%b exp=0", interrupcion); end
    // Hold the handler; matches accrue as one pending
    pulses = 0; idle_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (clock_out) pulses++;
      if (!in_service) idle_cnt++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL tmr_no_nesting got=%0d exp=0", pulses); end
    total++; if (idle_cnt !== 0) begin bad++; $display("FAIL tmr_held_service got=%0d exp=0", idle_cnt); end
    pop = 1'b1;
    step();  // E0+15 return
    pop = 1'b0;
    step();  // E0+16 accrued tick dispatched
    total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL tmr_accrued got=%b exp=1", clock_out); end
    // Prompt returns: pulses every 3 clocks
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL tmr_width_%0d got=%b exp=0", k, clock_out); end
      pop = 1'b1;
      step();
      pop = 1'b0;
      total++; if (in_service !== 1'b0) begin bad++; $display("FAIL tmr_ret_%0d got=%b exp=0", k, in_service); end
      step();
      total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL tmr_period_%0d got=%b exp=1", k, clock_out); end
    end
    // Disable timer (umbral=0) and return
    enable = 1'b1; conf_data = 8'b00_000000;
    step();
    enable = 1'b0;
    pop = 1'b1;
    step();
    pop = 1'b0;
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL tmr_off_ret got=%b exp=0", in_service); end
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (clock_out || interrupcion) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL tmr_disabled got=%0d exp=0", pulses); end
  endtask

  task automatic test_prescaler();
    int pulses;
    enable = 1'b1; conf_data = 8'b01_000001;
    step();  // E0
    enable = 1'b0; conf_data = 8'd0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (clock_out) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL psc_early got=%0d exp=0", pulses); end
    step();  // E0+17
    total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL psc_div16 got=%b exp=1", clock_out); end
    enable = 1'b1; conf_data = 8'd0;
    step();
    enable = 1'b0;
    pop = 1'b1;
    step();
    pop = 1'b0;
    step();
  endtask

  task automatic test_priority();
    int pulses;
    enable = 1'b1; conf_data = 8'b00_000011;
    step();  // E0
    enable = 1'b0; conf_data = 8'd0;
    step(); step();
    irq_ext = 4'b1010;
    step();  // E0+3: timer match and both edges together
    step();  // E0+4
    total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL pri_timer_first got=%b exp=1", clock_out); end
    total++; if (interrupcion !== 1'b0) begin bad++; $display("FAIL pri_no_ext got=%b exp=0", interrupcion); end
    enable = 1'b1;
    step();  // E0+5: timer off, ext pendings untouched
    enable = 1'b0;
    pop = 1'b1;
    step();  // E0+6
    pop = 1'b0;
    step();  // E0+7
    total++; if (interrupcion !== 1'b1) begin bad++; $display("FAIL pri_second_pulse got=%b exp=1", interrupcion); end
    total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL pri_second_id got=%0d exp=2", irq_id); end
    step();
    pop = 1'b1;
    step();  // E0+9
    pop = 1'b0;
    step();  // E0+10
    total++; if (interrupcion !== 1'b1) begin bad++; $display("FAIL pri_third_pulse got=%b exp=1", interrupcion); end
    total++; if (irq_id !== 3'd4) begin bad++; $display("FAIL pri_third_id got=%0d exp=4", irq_id); end
    step();
    pop = 1'b1;
    step();
    pop = 1'b0;
    irq_ext = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (interrupcion || clock_out) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL pri_drained got=%0d exp=0", pulses); end
  endtask

  task automatic test_depth();
    irq_ext = 4'b0001;
    step();
    step();  // FIRE
    total++; if (interrupcion !== 1'b1) begin bad++; $display("FAIL dep_pulse got=%b exp=1", interrupcion); end
    push = 1'b1; s_interrupcion = 1'b1;
    step();  // push of the interrupt itself, in FIRE
    step();  // interrupt-flagged push in SERVICE is not counted either
    s_interrupcion = 1'b0;
    step();  // depth 1
    step();  // depth 2
    pop = 1'b1;
    step();  // push+pop: pop wins, depth 1
    push = 1'b0;
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL dep_pop1 got=%b exp=1", in_service); end
    step();  // depth 0
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL dep_pop2 got=%b exp=1", in_service); end
    step();  // end of service
    pop = 1'b0;
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL dep_return got=%b exp=0", in_service); end
    irq_ext = 4'b0000;
    step();
  endtask

  task automatic test_held();
    int pulses;
    int bad_id;
    irq_ext = 4'b0100;
    pulses = 0; bad_id = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (interrupcion) begin
        pulses++;
        if (irq_id != 3'd3) bad_id++;
      end
      pop = in_service;
    end
    pop = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL held_single got=%0d exp=1", pulses); end
    total++; if (bad_id !== 0) begin bad++; $display("FAIL held_irq_id got=%0d exp=0", bad_id); end
    irq_ext = 4'b0000;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int pulses;
    int busy;
    irq_ext = 4'b1000;
    step(); step(); step();  // SERVICE with irq_id=4
    irq_ext = 4'b1011;
    step();  // pend bits 1 and 2
    irq_ext = 4'b0000;
    step();
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", in_service); end
    reset = 1'b1;
    step();
    total++; if (interrupcion !== 1'b0) begin bad++; $display("FAIL mid_interrupcion got=%b exp=0", interrupcion); end
    total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL mid_clock_out got=%b exp=0", clock_out); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL mid_irq_id got=%0d exp=0", irq_id); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL mid_in_service got=%b exp=0", in_service); end
    reset = 1'b0;
    pulses = 0; busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (interrupcion || clock_out) pulses++;
      if (in_service) busy++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_pulse got=%0d exp=0", pulses); end
    total++; if (busy !== 0) begin bad++; $display("FAIL mid_idle got=%0d exp=0", busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ext_irq();
    test_timer();
    test_prescaler();
    test_priority();
    test_depth();
    test_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
